nco_tdm_sched: RTL and testbench

- Time-division scheduler that shares one sine lookup pipeline between NCH numerically-controlled-oscillator channels.
- Holds one phase accumulator per channel and visits the channels round-robin, one slot per clock.
- Issues each channel's truncated phase to the shared sine lookup, tracks the lookup latency with a tag pipeline, and returns each channel's sine sample with a channel index and a valid strobe.
- Sits between the configuration interface and the sine LUT/inversion block; downstream mixers take out_dat/out_ch/out_vld.

---
 rtl/nco_tdm_sched.sv | 207 ++++++++++++++++++++
 tb/tb_nco_tdm_sched.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_tdm_sched.sv
// ---------------------------------------------------------------------------
// nco_tdm_sched
//
// Time-division scheduler that shares one sine lookup between NCH
// numerically-controlled oscillators. One slot per clock visits the channels
// round-robin. Each visit:
//   - issues the channel's truncated phase to the lookup,
//   - updates the channel's phase accumulator,
//   - launches a tag that returns with the lookup result LAT clocks later.
// Frequency words are double-buffered (shadow -> active). The transfer happens
// only on a frame boundary so that every channel changes frequency together.
//
// Optional build macro: PHASE_DITHER_EN
//   When defined, a 16-bit LFSR adds dither below the phase truncation point
//   before the phase is issued. The accumulators themselves stay undithered.
//
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   cfg_we_i       write cfg_freq_i into the shadow frequency of cfg_ch_i
//   cfg_ch_i       shadow register select (values >= NCH are ignored)
//   cfg_freq_i     frequency word (unsigned phase increment)
//   cfg_commit_i   request shadow -> active transfer at the next frame boundary
//   commit_pend_o  a commit is requested but not yet applied
//   ch_en_i        per-channel run enable
//   ph_clr_i       per-channel phase clear, sampled in that channel's slot
//   phs_o          phase presented to the shared sine lookup
//   sin_i          signed sample returned by the sine lookup
//   out_dat_o      sample for channel out_ch_o
//   out_ch_o       channel index of out_dat_o
//   out_vld_o      out_dat_o/out_ch_o valid
//   frame_o        high in the cycle where slot 0 is processed
// ---------------------------------------------------------------------------
module nco_tdm_sched #(
    parameter int NCH = 4,
    parameter int CSZ = 2,
    parameter int ASZ = 24,
    parameter int PSZ = 12,
    parameter int OSZ = 18,
    parameter int LAT = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cfg_we_i,
    input  logic [CSZ-1:0]        cfg_ch_i,
    input  logic [ASZ-1:0]        cfg_freq_i,
    input  logic                  cfg_commit_i,
    output logic                  commit_pend_o,
    input  logic [NCH-1:0]        ch_en_i,
    input  logic [NCH-1:0]        ph_clr_i,
    output logic [PSZ-1:0]        phs_o,
    input  logic signed [OSZ-1:0] sin_i,
    output logic signed [OSZ-1:0] out_dat_o,
    output logic [CSZ-1:0]        out_ch_o,
    output logic                  out_vld_o,
    output logic                  frame_o
);

    localparam logic [CSZ-1:0] LAST_SLOT = CSZ'(NCH - 1);

    logic [CSZ-1:0]           slot_q;
    logic [CSZ-1:0]           slot_d;
    logic                     commit_pend_q;
    logic                     commit_pend_d;
    logic                     commit_now;
    logic [NCH-1:0][ASZ-1:0]  acc_vec;
    logic [ASZ-1:0]           acc_sel;
    logic [PSZ-1:0]           phs_q;
    logic [PSZ-1:0]           phs_d;
    logic                     tag_vld_d;
    logic [LAT:0]             tag_vld_q;
    logic [LAT:0][CSZ-1:0]    tag_ch_q;
    logic signed [OSZ-1:0]    out_dat_q;
    logic [CSZ-1:0]           out_ch_q;
    logic                     out_vld_q;

    // Commit fires in the last slot of a frame; a request arriving in that
    // very cycle is honoured immediately rather than waiting a whole frame.
    assign commit_now    = (slot_q == LAST_SLOT) && (commit_pend_q || cfg_commit_i);
    assign commit_pend_d = commit_now ? 1'b0 : (cfg_commit_i ? 1'b1 : commit_pend_q);
    assign slot_d        = (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;

    // ---------------------------------------------------------------------
    // Per-channel state: accumulator, shadow and active frequency.
    // Active copies the pre-write shadow, so a cfg_we landing on the commit
    // cycle only reaches the shadow and needs a later commit to take effect.
    // ---------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [ASZ-1:0] acc_q;
            logic [ASZ-1:0] acc_d;
            logic [ASZ-1:0] shadow_q;
            logic [ASZ-1:0] shadow_d;
            logic [ASZ-1:0] active_q;
            logic [ASZ-1:0] active_d;
            logic           slot_hit;

            assign slot_hit = (slot_q == CSZ'(gi));

            always_comb begin
                acc_d = acc_q;
                if (slot_hit) begin
                    // Clear takes priority over advance.
                    if (ph_clr_i[gi]) begin
                        acc_d = '0;
                    end else if (ch_en_i[gi]) begin
                        acc_d = acc_q + active_q;
                    end
                end
                active_d = commit_now ? shadow_q : active_q;
                shadow_d = (cfg_we_i && (cfg_ch_i == CSZ'(gi))) ? cfg_freq_i : shadow_q;
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    acc_q    <= '0;
                    shadow_q <= '0;
                    active_q <= '0;
                end else begin
                    acc_q    <= acc_d;
                    shadow_q <= shadow_d;
                    active_q <= active_d;
                end
            end

            assign acc_vec[gi] = acc_q;
        end
    endgenerate

    // Pre-update accumulator of the channel in the current slot.
    assign acc_sel   = acc_vec[slot_q];
    // A clear always returns a valid sample (phase restarts from 0).
    assign tag_vld_d = ch_en_i[slot_q] | ph_clr_i[slot_q];

`ifdef PHASE_DITHER_EN
    // Fibonacci LFSR x^16 + x^15 + x^13 + x^4 + 1, stepped every clock.
    logic [15:0]    lfsr_q;
    logic [15:0]    lfsr_d;
    logic [ASZ-1:0] dither;
    logic [ASZ-1:0] phs_sum;

    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3]};

    // Dither fills only the bits discarded by truncation; any bits beyond
    // the LFSR width stay zero.
    always_comb begin
        dither = '0;
        for (int i = 0; (i < ASZ - PSZ) && (i < 16); i++) begin
            dither[i] = lfsr_q[i];
        end
    end

    assign phs_sum = acc_sel + dither;
    assign phs_d   = phs_sum[ASZ-1 -: PSZ];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign phs_d = acc_sel[ASZ-1 -: PSZ];
`endif

    // ---------------------------------------------------------------------
    // Slot counter, commit flag, issued phase, tag pipeline and output stage.
    // The tag launched with phs_q reaches stage LAT in the cycle where sin_i
    // holds the matching lookup result.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_q        <= '0;
            commit_pend_q <= 1'b0;
            phs_q         <= '0;
            tag_vld_q     <= '0;
            tag_ch_q      <= '0;
            out_dat_q     <= '0;
            out_ch_q      <= '0;
            out_vld_q     <= 1'b0;
        end else begin
            slot_q        <= slot_d;
            commit_pend_q <= commit_pend_d;
            phs_q         <= phs_d;
            tag_vld_q[0]  <= tag_vld_d;
            tag_ch_q[0]   <= slot_q;
            for (int i = 1; i <= LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_ch_q[i]  <= tag_ch_q[i-1];
            end
            out_dat_q     <= sin_i;
            out_ch_q      <= tag_ch_q[LAT];
            out_vld_q     <= tag_vld_q[LAT];
        end
    end

    assign commit_pend_o = commit_pend_q;
    assign phs_o         = phs_q;
    assign out_dat_o     = out_dat_q;
    assign out_ch_o      = out_ch_q;
    assign out_vld_o     = out_vld_q;
    // Forced low while reset is held so the reset state reads frame=0.
    assign frame_o       = rst_ni & (slot_q == '0);

endmodule

// File: tb/tb_nco_tdm_sched.sv
// ---------------------------------------------------------------------------
// tb_nco_tdm_sched
//
// Directed bench for nco_tdm_sched (NCH=4, ASZ=24, PSZ=12, OSZ=18, LAT=3).
// A behavioural model of channels, frequencies and the sample return path
// runs alongside the DUT and is compared against it every clock. Directed
// steps add literal expectations for timing, commit behaviour, wrap and clear.
// The sine lookup is stood in for by phs_out delayed three clocks, so each
// returned sample equals the phase its channel issued.
// ---------------------------------------------------------------------------
module tb_nco_tdm_sched;

    localparam int NCH = 4;
    localparam int CSZ = 2;
    localparam int ASZ = 24;
    localparam int PSZ = 12;
    localparam int OSZ = 18;
    localparam int LAT = 3;
    localparam int ODEL = LAT + 1;   // model delay-line depth to the output regs

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  cfg_we = 1'b0;
    logic [CSZ-1:0]        cfg_ch = '0;
    logic [ASZ-1:0]        cfg_freq = '0;
    logic                  cfg_commit = 1'b0;
    logic                  commit_pend;
    logic [NCH-1:0]        ch_en = '0;
    logic [NCH-1:0]        ph_clr = '0;
    logic [PSZ-1:0]        phs_out;
    logic signed [OSZ-1:0] sin_in;
    logic signed [OSZ-1:0] out_dat;
    logic [CSZ-1:0]        out_ch;
    logic                  out_vld;
    logic                  frame;

    always #5 clk = ~clk;

    nco_tdm_sched #(
        .NCH(NCH), .CSZ(CSZ), .ASZ(ASZ), .PSZ(PSZ), .OSZ(OSZ), .LAT(LAT)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cfg_we_i     (cfg_we),
        .cfg_ch_i     (cfg_ch),
        .cfg_freq_i   (cfg_freq),
        .cfg_commit_i (cfg_commit),
        .commit_pend_o(commit_pend),
        .ch_en_i      (ch_en),
        .ph_clr_i     (ph_clr),
        .phs_o        (phs_out),
        .sin_i        (sin_in),
        .out_dat_o    (out_dat),
        .out_ch_o     (out_ch),
        .out_vld_o    (out_vld),
        .frame_o      (frame)
    );

    // Stand-in sine lookup: result is the phase seen three clocks earlier.
    logic [PSZ-1:0] h1 = '0;
    logic [PSZ-1:0] h2 = '0;
    logic [PSZ-1:0] h3 = '0;
    always @(posedge clk) begin
        h1 <= phs_out;
        h2 <= h1;
        h3 <= h2;
    end
    assign sin_in = {{(OSZ-PSZ){1'b0}}, h3};

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural model ----------------
    int             m_slot;
    logic [ASZ-1:0] m_acc [NCH];
    logic [ASZ-1:0] m_sh  [NCH];
    logic [ASZ-1:0] m_act [NCH];
    bit             m_pend;
    logic [PSZ-1:0] m_phs;
    logic [PSZ-1:0] d_ph  [ODEL+1];
    bit             d_vld [ODEL+1];
    int             d_ch  [ODEL+1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_slot = 0;
        m_pend = 1'b0;
        m_phs  = '0;
        for (int c = 0; c < NCH; c++) begin
            m_acc[c] = '0;
            m_sh[c]  = '0;
            m_act[c] = '0;
        end
        for (int i = 0; i <= ODEL; i++) begin
            d_ph[i]  = '0;
            d_vld[i] = 1'b0;
            d_ch[i]  = 0;
        end
    endfunction

    // One clock of the scheduler as seen from outside: the channel in the
    // current slot issues its phase, then its accumulator moves on.
    function automatic void model_clock();
        int  s;
        bit  commit;
        s      = m_slot;
        commit = (s == NCH - 1) && (m_pend || cfg_commit);
        for (int i = ODEL; i > 0; i--) begin
            d_ph[i]  = d_ph[i-1];
            d_vld[i] = d_vld[i-1];
            d_ch[i]  = d_ch[i-1];
        end
        m_phs    = m_acc[s][ASZ-1 -: PSZ];
        d_ph[0]  = m_phs;
        d_vld[0] = ch_en[s] | ph_clr[s];
        d_ch[0]  = s;
        if (ph_clr[s])     m_acc[s] = '0;
        else if (ch_en[s]) m_acc[s] = m_acc[s] + m_act[s];
        if (commit) begin
            for (int c = 0; c < NCH; c++) m_act[c] = m_sh[c];
            m_pend = 1'b0;
        end else if (cfg_commit) begin
            m_pend = 1'b1;
        end
        if (cfg_we) m_sh[cfg_ch] = cfg_freq;
        m_slot = (s + 1) % NCH;
    endfunction

    task automatic compare();
        chk("phs_out", 32'(phs_out), 32'(m_phs));
        chk("frame", 32'(frame), 32'(rst_n && (m_slot == 0)));
        chk("commit_pend", 32'(commit_pend), 32'(m_pend));
        chk("out_vld", 32'(out_vld), 32'(d_vld[ODEL]));
        if (d_vld[ODEL]) begin
            chk("out_ch", 32'(out_ch), 32'(d_ch[ODEL]));
            chk("out_dat", 32'(out_dat), {{(32-PSZ){1'b0}}, d_ph[ODEL]});
        end
    endtask

    // Advance one clock: model on the edge, compare 1 time unit later, then
    // return at the falling edge where stimulus may change.
    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_clock();
        #1;
        compare();
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_slot(input int s);
        for (int i = 0; i < NCH && m_slot != s; i++) step();
    endtask

    task automatic wait_commit();
        for (int i = 0; i < 2 * NCH && commit_pend; i++) step();
        chk("commit_applied", 32'(commit_pend), 32'd0);
    endtask

    task automatic write_freq(input int ch, input logic [ASZ-1:0] f);
        cfg_we = 1'b1; cfg_ch = CSZ'(ch); cfg_freq = f;
        step();
        cfg_we = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [PSZ-1:0] p0;
    logic [PSZ-1:0] p_exp;

    initial begin
        model_reset();
        // ---- reset state ----
        steps(2);
        chk("rst_phs", 32'(phs_out), 32'd0);
        chk("rst_out_vld", 32'(out_vld), 32'd0);
        chk("rst_frame", 32'(frame), 32'd0);
        chk("rst_pend", 32'(commit_pend), 32'd0);

        // ---- ch0 only, zero frequency: first out_vld LAT+2 after frame ----
        ch_en = 4'b0001;
        rst_n = 1'b1;
        #1;
        chk("first_frame", 32'(frame), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk($sformatf("first_vld_%0d", i), 32'(out_vld), (i == 5) ? 32'd1 : 32'd0);
        end
        chk("first_ch", 32'(out_ch), 32'd0);
        steps(12);
        chk("phs_zero", 32'(phs_out), 32'd0);

        // ---- ch1 freq 0x100000 after commit: phase 0,0x100,0x200,0x300 ----
        wait_slot(0);
        write_freq(1, 24'h100000);
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
        chk("pend_set", 32'(commit_pend), 32'd1);
        ch_en = 4'b0010;
        wait_commit();
        chk("commit_at_frame", 32'(frame), 32'd1);
        wait_slot(2);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ch1_phase_%0d", k), 32'(phs_out), 32'(k * 32'h100));
            steps(NCH);
        end

        // ---- ch0 freq 0xFFFFFF for 4097 visits: modulo-2^24 wrap ----
        ch_en = 4'b0011;
        write_freq(0, 24'hFFFFFF);
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
        wait_commit();
        wait_slot(1);
        chk("wrap_k0", 32'(phs_out), 32'd0);
        for (int k = 1; k <= 4097; k++) begin
            steps(NCH);
            if (k == 1)    chk("wrap_k1", 32'(phs_out), 32'hFFF);
            if (k == 4096) chk("wrap_k4096", 32'(phs_out), 32'hFFF);
            if (k == 4097) chk("wrap_k4097", 32'(phs_out), 32'hFFE);
        end

        // ---- write ch2 on the commit cycle: active takes the old shadow ----
        wait_slot(0);
        write_freq(2, 24'h010000);
        wait_slot(3);
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_freq = 24'h020000;
        cfg_commit = 1'b1;
        ch_en = 4'b0111;
        step();
        cfg_we = 1'b0;
        cfg_commit = 1'b0;
        chk("same_cycle_no_pend", 32'(commit_pend), 32'd0);
        wait_slot(3);
        chk("ch2_old_0", 32'(phs_out), 32'd0);
        steps(NCH);
        chk("ch2_old_1", 32'(phs_out), 32'h010);
        steps(NCH);
        chk("ch2_old_2", 32'(phs_out), 32'h020);
        wait_slot(0);
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
        wait_commit();
        wait_slot(3);
        p0 = phs_out;
        steps(NCH);
        p_exp = p0 + 12'h020;
        chk("ch2_new_step", 32'(phs_out), 32'(p_exp));

        // ---- clear beats advance on ch3; clear on a disabled ch1 ----
        write_freq(3, 24'h300000);
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
        ch_en = 4'b1111;
        wait_commit();
        steps(12);
        wait_slot(3);
        ph_clr = 4'b1000;
        step();
        ph_clr = 4'b0000;
        wait_slot(3);
        step();
        chk("clr_next_phase", 32'(phs_out), 32'd0);
        chk("clr_out_vld", 32'(out_vld), 32'd1);
        chk("clr_out_ch", 32'(out_ch), 32'd3);
        ch_en = 4'b1101;
        wait_slot(1);
        ph_clr = 4'b0010;
        step();
        ph_clr = 4'b0000;
        steps(16);

        // ---- mid-frame reset discards in-flight tags ----
        wait_slot(2);
        rst_n = 1'b0;
        steps(2);
        rst_n = 1'b1;
        steps(4);
        chk("post_rst_no_vld", 32'(out_vld), 32'd0);
        steps(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
